keccak_sbox_share_codec: RTL and testbench
==========================================

Name: keccak_sbox_share_codec

Overview:
- Three-share (second-order) masking front/back end for the DOM-protected Keccak chi S-box row.
- Accepts an unmasked 5-bit row over valid/ready and splits it into shares ax/bx/cx.
- Generates the fresh DOM randomness z0/z1/z2, holds both stable for the S-box latency, then recombines ay^by^cy into an unmasked result.
- Sits between the unprotected test/control logic and the masked S-box; the S-box is instantiated outside this block.

Parameters:
- SBOX_LAT, 1: register stages in the masked S-box (DOM AND stage); legal range 1..7.
- SEED, 31'h1ACE_5EED: initial 31-bit LFSR state; SEED==0 is replaced by 31'h1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  unmasked row valid.
- in_ready  out  1  block can accept a row.
- in_data  in  5  unmasked row x[4:0].
- ax, bx, cx  out  5 each  input shares to the S-box.
- z0, z1, z2  out  5 each  fresh DOM randomness to the S-box.
- ay, by, cy  in  5 each  output shares from the S-box.
- out_valid  out  1  unmasked result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  5  unmasked result chi(x).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, LFSR=SEED.
  - Outputs ax/bx/cx/z0/z1/z2/out_data = 0; out_valid = 0.
  - in_ready = 0 while rst=0.
  - Reset mid-operation discards any in-flight row; no partial output.
- LFSR: 31-bit Fibonacci LFSR, polynomial x^31+x^28+1. It advances exactly 25 steps (unrolled leap) per accepted row and is otherwise frozen. Bits r[9:0] are the mask bits; bits r[24:10] are the randomness bits.
- FSM states: IDLE, DRIVE, OUT.
  - IDLE: in_ready=1 and share/randomness outputs are 0. On in_valid=1, register the following, load cnt=SBOX_LAT, and go to DRIVE:
    - m0=r[4:0], m1=r[9:5]
    - ax=in_data^m0^m1, bx=m0, cx=m1
    - z0=r[14:10], z1=r[19:15], z2=r[24:20]
  - DRIVE: in_ready=0; ax..z2 held stable. cnt decrements each cycle. In the cycle with cnt==0, out_data<=ay^by^cy is captured, ax..z2 are cleared to 0, and the FSM goes to OUT.
  - OUT: out_valid=1 and out_data held. On out_ready=1, go to IDLE with out_valid=0 next cycle. out_data keeps its value until the next capture.
- Latency: with the accept edge at cycle k, out_valid is first high in cycle k+SBOX_LAT+2 (SBOX_LAT=1 gives 3 cycles). Throughput is 1 row per SBOX_LAT+3 cycles minimum.
- Boundaries:
  - in_valid is ignored outside IDLE.
  - out_ready while out_valid=0 has no effect.
  - out_ready held high with in_valid high gives back-to-back rows: OUT then IDLE then accept.
  - The unmasked in_data never appears combinationally on any share port. Only ax carries it, and always XORed with two fresh masks.

Optional Feature:
- Macro SBOX_SELFCHECK_EN.
- Defined:
  - The block latches in_data into a shadow register at accept.
  - At capture it computes the reference chi: y[i]=x[i]^(~x[i+1]&x[i+2]), indices mod 5.
  - Extra output port mismatch (1 bit) is set when the decoded value differs from the reference. It is sticky until reset; reset value is 0.
- Undefined: no shadow register, no mismatch port. The unmasked value is not stored anywhere in the block (production build).

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, DRIVE=2'd1, OUT=2'd2)
  - LFSR width (31) and taps (31,28)
  - share width (5)
  - per-row randomness count (25 = 10 mask + 15 DOM)
- One sub-module is natural: keccak_lfsr_leap, which is the 31-bit LFSR with parameterised step count (25), enable, and seed.
- The FSM, share registers, and decoder stay in the top module.

Test Plan:
- Bench setup: a reference masked S-box model with SBOX_LAT=1 is connected back-to-back.
- in_data=5'h00, out_ready=1 -> out_data=5'h00, out_valid high exactly 3 cycles after the accept edge; in_ready low in between.
- in_data=5'h1F -> out_data=5'h1F. in_data=5'h01 -> 5'h09. in_data=5'h02 -> 5'h12.
- Exhaustive check over all 32 inputs, with out_ready random stalls up to 5 cycles -> every out_data equals chi(x); out_data stable while out_valid && !out_ready.
- Same in_data=5'h01 sent twice -> bx/cx differ between the two transactions (LFSR advanced 25 steps); ax^bx^cx==5'h01 both times; share ports read 0 in IDLE.
- rst pulled low during DRIVE -> out_valid stays 0, all outputs 0 immediately. After release, LFSR==SEED and the next row decodes correctly.
- SBOX_SELFCHECK_EN defined, model corrupts ay[2] once -> mismatch rises at the capture cycle and stays high until reset.

Source files
------------

// File: rtl/keccak_sbox_share_codec_pkg.sv
// Shared constants for the three-share chi row codec: FSM encoding, LFSR geometry, share width.
// Also holds the LFSR single-step and reference chi helpers.
package keccak_sbox_share_codec_pkg;
  localparam int LFSR_W    = 31;
  localparam int TAP_A     = 31;
  localparam int TAP_B     = 28;
  localparam int SHARE_W   = 5;
  localparam int MASK_BITS = 10;
  localparam int DOM_BITS  = 15;
  localparam int ROW_RAND  = MASK_BITS + DOM_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  // Fibonacci step for x^31+x^28+1: shift up, feed back bit 31 ^ bit 28.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_A-1] ^ s[TAP_B-1]};
  endfunction

  function automatic logic [SHARE_W-1:0] chi_row(input logic [SHARE_W-1:0] x);
    logic [SHARE_W-1:0] y;
    y = '0;
    for (int i = 0; i < SHARE_W; i++)
      y[i] = x[i] ^ (~x[(i + 1) % SHARE_W] & x[(i + 2) % SHARE_W]);
    return y;
  endfunction
endpackage

// File: rtl/keccak_sbox_share_codec_lfsr_leap.sv
// 31-bit LFSR advancing STEPS positions per enabled cycle (unrolled leap); frozen otherwise.
// Exposes the low ROW_RAND bits as the per-row randomness.
module keccak_lfsr_leap
  import keccak_sbox_share_codec_pkg::*;
#(
  parameter int                STEPS = ROW_RAND,
  parameter logic [LFSR_W-1:0] SEED  = 31'h1ACE_5EED
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [ROW_RAND-1:0] rnd
);
  // An all-zero state would lock the LFSR, so a zero seed falls back to 1.
  localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] nxt;

  always_comb begin
    nxt = state;
    for (int i = 0; i < STEPS; i++) nxt = lfsr_step(nxt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state <= INIT;
    else if (en) state <= nxt;
  end

  assign rnd = state[ROW_RAND-1:0];
endmodule

// File: rtl/keccak_sbox_share_codec.sv
// Three-share masking codec around an external DOM chi S-box row: split, drive randomness, recombine.
// Optional SBOX_SELFCHECK_EN adds a shadow of the input and a sticky mismatch flag.
module keccak_sbox_share_codec
  import keccak_sbox_share_codec_pkg::*;
#(
  parameter int                SBOX_LAT = 1,
  parameter logic [LFSR_W-1:0] SEED     = 31'h1ACE_5EED
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_data,
  output logic [4:0]   ax,
  output logic [4:0]   bx,
  output logic [4:0]   cx,
  output logic [4:0]   z0,
  output logic [4:0]   z1,
  output logic [4:0]   z2,
  input  logic [4:0]   ay,
  input  logic [4:0]   by,
  input  logic [4:0]   cy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_data
`ifdef SBOX_SELFCHECK_EN
  ,
  output logic         mismatch
`endif
);
  logic [1:0]          state;
  logic [2:0]          cnt;
  logic [ROW_RAND-1:0] rnd;
  logic [SHARE_W-1:0]  m0, m1;
  logic                accept, capture;

  assign in_ready  = rst && (state == ST_IDLE);
  assign accept    = in_ready && in_valid;
  assign capture   = (state == ST_DRIVE) && (cnt == 3'd0);
  assign out_valid = (state == ST_OUT);
  assign m0        = rnd[4:0];
  assign m1        = rnd[9:5];

  keccak_lfsr_leap #(.STEPS(ROW_RAND), .SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .rnd (rnd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      ax       <= '0;
      bx       <= '0;
      cx       <= '0;
      z0       <= '0;
      z1       <= '0;
      z2       <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // The plain row only ever leaves this block folded with two fresh masks.
            ax    <= in_data ^ m0 ^ m1;
            bx    <= m0;
            cx    <= m1;
            z0    <= rnd[14:10];
            z1    <= rnd[19:15];
            z2    <= rnd[24:20];
            cnt   <= 3'(SBOX_LAT);
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (capture) begin
            out_data <= ay ^ by ^ cy;
            ax       <= '0;
            bx       <= '0;
            cx       <= '0;
            z0       <= '0;
            z1       <= '0;
            z2       <= '0;
            state    <= ST_OUT;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SBOX_SELFCHECK_EN
  logic [SHARE_W-1:0] x_shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_shadow <= '0;
      mismatch <= 1'b0;
    end else begin
      if (accept) x_shadow <= in_data;
      if (capture && ((ay ^ by ^ cy) != chi_row(x_shadow))) mismatch <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_keccak_sbox_share_codec.sv
// Bench for keccak_sbox_share_codec with a behavioural one-stage masked chi model in the loop.
module tb_keccak_sbox_share_codec;
  localparam logic [30:0] TB_SEED = 31'h1ACE_5EED;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = 5'h00;
  logic [4:0] ax, bx, cx, z0, z1, z2;
  logic [4:0] ay, by, cy;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_data;
  logic       corrupt = 1'b0;
`ifdef SBOX_SELFCHECK_EN
  logic       mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keccak_sbox_share_codec #(.SBOX_LAT(1), .SEED(TB_SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ax        (ax),
    .bx        (bx),
    .cx        (cx),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .ay        (ay),
    .by        (by),
    .cy        (cy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SBOX_SELFCHECK_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  function automatic logic [4:0] ref_chi(input logic [4:0] x);
    logic [4:0] y;
    y = '0;
    for (int i = 0; i < 5; i++) y[i] = x[i] ^ (~x[(i + 1) % 5] & x[(i + 2) % 5]);
    return y;
  endfunction

  // Masked S-box stand-in: one register stage, output re-shared with fresh randomness.
  logic [4:0] sb_x, sb_r1, sb_r2;
  always @(posedge clk) begin
    sb_x  <= ax ^ bx ^ cx;
    sb_r1 <= 5'($urandom);
    sb_r2 <= 5'($urandom);
  end
  assign ay = ref_chi(sb_x) ^ sb_r1 ^ sb_r2 ^ {2'b00, corrupt, 2'b00};
  assign by = sb_r1;
  assign cy = sb_r2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_row(input logic [4:0] x, input int stall, input logic [4:0] flip,
                        output logic [4:0] sb, output logic [4:0] sc);
    int cyc;
    bit ok;
    in_valid = 1'b1;
    in_data  = x;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    chk("in_ready_wait", 32'(ok), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 5'($urandom);
    cyc = 1;
    sb = bx;
    sc = cx;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    chk("share_xor", 32'(ax ^ bx ^ cx), 32'(x));
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid !== 1'b1) chk("in_ready_drive", 32'(in_ready), 32'd0);
    end
    chk("latency", 32'(cyc), 32'd3);
    chk("shares_cleared", 32'({ax, bx, cx, z0, z1, z2}), 32'd0);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(ref_chi(x) ^ flip));
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("out_data", 32'(out_data), 32'(ref_chi(x) ^ flip));
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("idle_shares_zero", 32'({ax, bx, cx, z0, z1, z2}), 32'd0);
  endtask

  logic [4:0] b1, c1, b2, c2, b0, c0, tmp_b, tmp_c;

  initial begin
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({ax, bx, cx, z0, z1, z2, out_data}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // First row after reset uses the seed bits directly as masks.
    do_row(5'h00, 0, 5'h00, b0, c0);
    chk("seed_bx", 32'(b0), 32'(TB_SEED[4:0]));
    chk("seed_cx", 32'(c0), 32'(TB_SEED[9:5]));
    do_row(5'h1F, 0, 5'h00, tmp_b, tmp_c);
    do_row(5'h01, 1, 5'h00, b1, c1);
    do_row(5'h01, 2, 5'h00, b2, c2);
    chk("masks_fresh", 32'({b1, c1} != {b2, c2}), 32'd1);
    do_row(5'h02, 0, 5'h00, tmp_b, tmp_c);

    for (int i = 0; i < 32; i++) begin
      do_row(5'(i), int'($urandom_range(0, 5)), 5'h00, tmp_b, tmp_c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abort a row in flight.
    in_valid = 1'b1;
    in_data  = 5'h1F;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_in_drive", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({ax, bx, cx, z0, z1, z2, out_data}), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_valid_hold", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    do_row(5'h01, 0, 5'h00, tmp_b, tmp_c);
    chk("post_rst_seed_bx", 32'(tmp_b), 32'(b0));
    chk("post_rst_seed_cx", 32'(tmp_c), 32'(c0));

`ifdef SBOX_SELFCHECK_EN
    chk("mismatch_clean", 32'(mismatch), 32'd0);
    corrupt = 1'b1;
    do_row(5'h05, 0, 5'h04, tmp_b, tmp_c);
    corrupt = 1'b0;
    chk("mismatch_set", 32'(mismatch), 32'd1);
    do_row(5'h06, 1, 5'h00, tmp_b, tmp_c);
    chk("mismatch_sticky", 32'(mismatch), 32'd1);
    rst = 1'b0;
    #1;
    chk("mismatch_rst", 32'(mismatch), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
